// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-lite control FSM: sequences lw/sw/beq/ori/R/baln/jpc over 3-5 cycles,
// handshakes with shared memory, guards memory waits with a watchdog and traps on faults.
module multicycle_control #(
  parameter int EXT_EN   = 1,
  parameter int TRAP_EN  = 1,
  parameter int WAIT_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       link,
  output logic       reg31,
  output logic [3:0] state,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_EXEC_I  = 4'd9,
    S_IWB     = 4'd10,
    S_LINK_B  = 4'd11,
    S_LINK_J  = 4'd12,
    S_TRAP    = 4'd13
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BALN = 6'b011011;
  localparam logic [5:0] OP_JPC  = 6'b011110;

  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              fault_q, fault_d;
  logic [1:0]        fault_code_q, fault_code_d;

  logic illegal_op;
  logic timeout;
  logic wait_state;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    illegal_op   = 1'b0;
    timeout      = 1'b0;
    wait_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ORI:       state_d = S_EXEC_I;
          OP_BALN:      if (EXT_EN != 0) state_d = S_LINK_B; else illegal_op = 1'b1;
          OP_JPC:       if (EXT_EN != 0) state_d = S_LINK_J; else illegal_op = 1'b1;
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADDR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:  state_d = S_RWB;
      S_RWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_EXEC_I:  state_d = S_IWB;
      S_IWB:     state_d = S_FETCH;
      S_LINK_B:  state_d = S_FETCH;
      S_LINK_J:  state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase

    // A ready memory in the WAIT_MAX cycle still completes; only a stalled one times out.
    if (wait_state && !mem_ready) begin
      if (wait_cnt_q == WAIT_LIMIT) timeout = 1'b1;
      else wait_cnt_d = wait_cnt_q + 1'b1;
    end

    if (illegal_op || timeout) begin
      state_d = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
      if (!fault_q) begin
        fault_d      = 1'b1;
        fault_code_d = illegal_op ? FC_ILLEGAL : FC_TIMEOUT;
      end
    end

    if ((state_d != state_q) || illegal_op || timeout) wait_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    link        = 1'b0;
    reg31       = 1'b0;

    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        pcwrite = mem_ready;
        irwrite = mem_ready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADDR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXEC_R: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      S_EXEC_I: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
      end
      S_IWB:     regwrite = 1'b1;
      // PC was already advanced in FETCH, so the linked value is the return address.
      S_LINK_B: begin
        regwrite = 1'b1;
        link     = 1'b1;
        reg31    = 1'b1;
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      S_LINK_J: begin
        regwrite = 1'b1;
        link     = 1'b1;
        pcwrite  = 1'b1;
        pcsource = 2'b01;
      end
      default: ;
    endcase

    if (reset) begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      regwrite    = 1'b0;
      link        = 1'b0;
      reg31       = 1'b0;
    end
  end

  assign state      = state_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: three instances (default, EXT_EN=0, TRAP_EN=0)
// driven with hand-built opcode/handshake sequences and checked against hand-computed vectors.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BALN = 6'b011011;
  localparam logic [5:0] OP_JPC  = 6'b011110;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite}_{memtoreg,regdst,regwrite,alusrca}
  // _alusrcb_aluop_pcsource_{link,reg31}
  localparam logic [17:0] C_NONE       = 18'b000000_0000_00_00_00_00;
  localparam logic [17:0] C_FETCH_RDY  = 18'b100101_0000_01_00_00_00;
  localparam logic [17:0] C_FETCH_WAIT = 18'b000100_0000_01_00_00_00;
  localparam logic [17:0] C_FETCH_RST  = 18'b000000_0000_01_00_00_00;
  localparam logic [17:0] C_DECODE     = 18'b000000_0000_11_00_00_00;
  localparam logic [17:0] C_MEMADDR    = 18'b000000_0001_10_00_00_00;
  localparam logic [17:0] C_MEMRD      = 18'b001100_0000_00_00_00_00;
  localparam logic [17:0] C_MEMWB      = 18'b000000_1010_00_00_00_00;
  localparam logic [17:0] C_MEMWB_RST  = 18'b000000_1000_00_00_00_00;
  localparam logic [17:0] C_MEMWR      = 18'b001010_0000_00_00_00_00;
  localparam logic [17:0] C_MEMWR_RST  = 18'b001000_0000_00_00_00_00;
  localparam logic [17:0] C_EXEC_R     = 18'b000000_0001_00_10_00_00;
  localparam logic [17:0] C_RWB        = 18'b000000_0110_00_00_00_00;
  localparam logic [17:0] C_BRANCH     = 18'b010000_0001_00_01_01_00;
  localparam logic [17:0] C_EXEC_I     = 18'b000000_0001_10_11_00_00;
  localparam logic [17:0] C_IWB        = 18'b000000_0010_00_00_00_00;
  localparam logic [17:0] C_LINK_B     = 18'b100000_0010_00_00_10_11;
  localparam logic [17:0] C_LINK_J     = 18'b100000_0010_00_00_01_10;

  logic clk = 1'b0;
  logic reset;

  logic [5:0]  op [3];
  logic        mr [3];
  logic        pcwrite [3], pcwritecond [3], iord [3], memread [3], memwrite [3];
  logic        irwrite [3], memtoreg [3], regdst [3], regwrite [3], alusrca [3];
  logic        link [3], reg31 [3], fault [3];
  logic [1:0]  alusrcb [3], aluop [3], pcsource [3], fault_code [3];
  logic [3:0]  state [3];
  logic [17:0] ctl [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults, 1: extensions disabled, 2: faults return to FETCH.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_control #(
      .EXT_EN  (g == 1 ? 0 : 1),
      .TRAP_EN (g == 2 ? 0 : 1),
      .WAIT_W  (4),
      .WAIT_MAX(15)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op[g]),
      .mem_ready  (mr[g]),
      .pcwrite    (pcwrite[g]),
      .pcwritecond(pcwritecond[g]),
      .iord       (iord[g]),
      .memread    (memread[g]),
      .memwrite   (memwrite[g]),
      .irwrite    (irwrite[g]),
      .memtoreg   (memtoreg[g]),
      .regdst     (regdst[g]),
      .regwrite   (regwrite[g]),
      .alusrca    (alusrca[g]),
      .alusrcb    (alusrcb[g]),
      .aluop      (aluop[g]),
      .pcsource   (pcsource[g]),
      .link       (link[g]),
      .reg31      (reg31[g]),
      .state      (state[g]),
      .fault      (fault[g]),
      .fault_code (fault_code[g])
    );
    assign ctl[g] = {pcwrite[g], pcwritecond[g], iord[g], memread[g], memwrite[g], irwrite[g],
                     memtoreg[g], regdst[g], regwrite[g], alusrca[g], alusrcb[g], aluop[g],
                     pcsource[g], link[g], reg31[g]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input logic [5:0] o, input logic r);
    op[d] = o;
    mr[d] = r;
    #1;
  endtask

  task automatic stepCheck(input string tag, input int d, input logic [3:0] s, input logic [17:0] c);
    checkOutput({tag, "_state"}, 32'(state[d]), 32'(s));
    checkOutput({tag, "_ctl"}, 32'(ctl[d]), 32'(c));
    tick();
  endtask

  task automatic checkFault(input string tag, input int d, input logic f, input logic [1:0] code);
    checkOutput({tag, "_fault"}, 32'(fault[d]), 32'(f));
    checkOutput({tag, "_code"}, 32'(fault_code[d]), 32'(code));
  endtask

  task automatic resetPulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      op[d] = 6'b0;
      mr[d] = 1'b0;
    end

    // Reset held two cycles; strobes stay low even with memory ready.
    tick();
    applyStimulus(0, OP_LW, 1'b1);
    checkOutput("rst1_state", 32'(state[0]), 32'd0);
    checkOutput("rst1_ctl", 32'(ctl[0]), 32'(C_FETCH_RST));
    checkFault("rst1", 0, 1'b0, 2'b00);
    tick();
    checkOutput("rst2_ctl", 32'(ctl[0]), 32'(C_FETCH_RST));
    reset = 1'b0;
    #1;

    // lw, zero-wait: 0,1,2,3,4,0.
    stepCheck("lw_f", 0, 4'd0, C_FETCH_RDY);
    stepCheck("lw_d", 0, 4'd1, C_DECODE);
    stepCheck("lw_a", 0, 4'd2, C_MEMADDR);
    stepCheck("lw_r", 0, 4'd3, C_MEMRD);
    stepCheck("lw_wb", 0, 4'd4, C_MEMWB);

    // sw with three stalled cycles in MEMWR: memwrite held four cycles.
    applyStimulus(0, OP_SW, 1'b1);
    stepCheck("sw_f", 0, 4'd0, C_FETCH_RDY);
    stepCheck("sw_d", 0, 4'd1, C_DECODE);
    stepCheck("sw_a", 0, 4'd2, C_MEMADDR);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, OP_SW, i == 3);
      stepCheck($sformatf("sw_w%0d", i), 0, 4'd5, C_MEMWR);
    end
    checkFault("sw_end", 0, 1'b0, 2'b00);

    applyStimulus(0, OP_R, 1'b1);
    stepCheck("r_f", 0, 4'd0, C_FETCH_RDY);
    stepCheck("r_d", 0, 4'd1, C_DECODE);
    stepCheck("r_x", 0, 4'd6, C_EXEC_R);
    stepCheck("r_wb", 0, 4'd7, C_RWB);

    applyStimulus(0, OP_BEQ, 1'b1);
    stepCheck("beq_f", 0, 4'd0, C_FETCH_RDY);
    stepCheck("beq_d", 0, 4'd1, C_DECODE);
    stepCheck("beq_b", 0, 4'd8, C_BRANCH);

    applyStimulus(0, OP_ORI, 1'b1);
    stepCheck("ori_f", 0, 4'd0, C_FETCH_RDY);
    stepCheck("ori_d", 0, 4'd1, C_DECODE);
    stepCheck("ori_x", 0, 4'd9, C_EXEC_I);
    stepCheck("ori_wb", 0, 4'd10, C_IWB);

    applyStimulus(0, OP_BALN, 1'b1);
    stepCheck("baln_f", 0, 4'd0, C_FETCH_RDY);
    stepCheck("baln_d", 0, 4'd1, C_DECODE);
    stepCheck("baln_l", 0, 4'd11, C_LINK_B);

    applyStimulus(0, OP_JPC, 1'b1);
    stepCheck("jpc_f", 0, 4'd0, C_FETCH_RDY);
    stepCheck("jpc_d", 0, 4'd1, C_DECODE);
    stepCheck("jpc_l", 0, 4'd12, C_LINK_J);
    checkOutput("jpc_done_state", 32'(state[0]), 32'd0);

    // Fetch stall: counts 0..14 pass, the 16th stalled cycle (count 15) times out.
    applyStimulus(0, OP_LW, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    stepCheck("to_last", 0, 4'd0, C_FETCH_WAIT);
    checkFault("to_last", 0, 1'b1, 2'b10);
    applyStimulus(0, OP_LW, 1'b1);
    stepCheck("to_trap", 0, 4'd13, C_NONE);
    checkOutput("to_trap2_state", 32'(state[0]), 32'd13);

    // Same stall, but memory becomes ready exactly at count 15.
    resetPulse();
    applyStimulus(0, OP_ORI, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    applyStimulus(0, OP_ORI, 1'b1);
    stepCheck("rdy15_f", 0, 4'd0, C_FETCH_RDY);
    stepCheck("rdy15_d", 0, 4'd1, C_DECODE);
    checkFault("rdy15", 0, 1'b0, 2'b00);

    // Reset asserted while sw is stalled in MEMWR.
    stepCheck("swr_x", 0, 4'd9, C_EXEC_I);
    stepCheck("swr_wb", 0, 4'd10, C_IWB);
    applyStimulus(0, OP_SW, 1'b1);
    stepCheck("swr_f", 0, 4'd0, C_FETCH_RDY);
    stepCheck("swr_d", 0, 4'd1, C_DECODE);
    stepCheck("swr_a", 0, 4'd2, C_MEMADDR);
    applyStimulus(0, OP_SW, 1'b0);
    checkOutput("swr_wait_ctl", 32'(ctl[0]), 32'(C_MEMWR));
    reset = 1'b1;
    #1;
    checkOutput("swr_rst_ctl", 32'(ctl[0]), 32'(C_MEMWR_RST));
    tick();
    reset = 1'b0;
    #1;
    checkOutput("swr_after_state", 32'(state[0]), 32'd0);

    // EXT_EN=0: baln is illegal and parks in TRAP.
    resetPulse();
    applyStimulus(1, OP_BALN, 1'b1);
    stepCheck("nx_f", 1, 4'd0, C_FETCH_RDY);
    checkFault("nx_d", 1, 1'b0, 2'b00);
    stepCheck("nx_d", 1, 4'd1, C_DECODE);
    stepCheck("nx_trap", 1, 4'd13, C_NONE);
    checkFault("nx_trap", 1, 1'b1, 2'b01);

    // TRAP_EN=0: illegal opcode flags and returns; later timeout keeps code 01.
    resetPulse();
    applyStimulus(2, OP_BAD, 1'b1);
    stepCheck("nt_f", 2, 4'd0, C_FETCH_RDY);
    stepCheck("nt_d", 2, 4'd1, C_DECODE);
    checkOutput("nt_back_state", 32'(state[2]), 32'd0);
    checkFault("nt_back", 2, 1'b1, 2'b01);
    applyStimulus(2, OP_LW, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    checkOutput("nt_to_state", 32'(state[2]), 32'd0);
    checkFault("nt_to", 2, 1'b1, 2'b01);

    // lw on the same instance, reset in MEMWB clears the flags.
    applyStimulus(2, OP_LW, 1'b1);
    stepCheck("ntl_f", 2, 4'd0, C_FETCH_RDY);
    stepCheck("ntl_d", 2, 4'd1, C_DECODE);
    stepCheck("ntl_a", 2, 4'd2, C_MEMADDR);
    stepCheck("ntl_r", 2, 4'd3, C_MEMRD);
    checkOutput("ntl_wb_ctl", 32'(ctl[2]), 32'(C_MEMWB));
    reset = 1'b1;
    #1;
    checkOutput("ntl_rst_ctl", 32'(ctl[2]), 32'(C_MEMWB_RST));
    tick();
    reset = 1'b0;
    #1;
    checkOutput("ntl_after_state", 32'(state[2]), 32'd0);
    checkFault("ntl_after", 2, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
